// File: rtl/ac_reg_unit.sv
// ac_reg_unit -- processor accumulator (AC) with extend bit E, status flags,
// single-cycle micro-operations and a multi-cycle logical shift sequencer
// with a BUSY/DONE handshake.
// Optional feature: define AC_OVF_EN to build the signed-overflow flag OVF;
// without it OVF is tied low.
module ac_reg_unit #(
  parameter int WIDTH = 16,
  parameter int AMT_W = 4
) (
  input  logic             CLK,
  input  logic             CLR,
  input  logic             SCLR,
  input  logic [WIDTH-1:0] Data,
  input  logic             LD,
  input  logic             ADD,
  input  logic             INC,
  input  logic             CMA,
  input  logic             CIR,
  input  logic             CIL,
  input  logic             SH_START,
  input  logic             SH_DIR,
  input  logic [AMT_W-1:0] SH_AMT,
  output logic [WIDTH-1:0] Q,
  output logic             E,
  output logic             Z,
  output logic             N,
  output logic             BUSY,
  output logic             DONE,
  output logic             OVF
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_r;
  logic [WIDTH-1:0] q_r;
  logic             e_r;
  logic             busy_r;
  logic             done_r;
  logic [AMT_W-1:0] cnt_r;
  logic             dir_r;
  logic [WIDTH:0]   sum_s;

  localparam logic [AMT_W-1:0] CNT_ONE  = {{(AMT_W-1){1'b0}}, 1'b1};
  localparam logic [AMT_W-1:0] CNT_ZERO = {AMT_W{1'b0}};
  localparam logic [WIDTH-1:0] Q_ONE    = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] Q_ZERO   = {WIDTH{1'b0}};

  // Full-width sum; the extra top bit becomes the carry into E.
  assign sum_s = {1'b0, q_r} + {1'b0, Data};

`ifdef AC_OVF_EN
  logic ovf_r;

  // Two's-complement overflow: operands agree in sign, result does not.
  function automatic logic add_ovf(input logic a_msb, input logic b_msb,
                                   input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

  // Overflow flag: updated only by ADD, cleared by either clear.
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      ovf_r <= 1'b0;
    end else if (SCLR) begin
      ovf_r <= 1'b0;
    end else if ((state_r == IDLE) && !LD && ADD) begin
      ovf_r <= add_ovf(q_r[WIDTH-1], Data[WIDTH-1], sum_s[WIDTH-1]);
    end else begin
      ovf_r <= ovf_r;
    end
  end

  assign OVF = ovf_r;
`else
  assign OVF = 1'b0;
`endif

  // Accumulator, E and the shift sequencer: one prioritised command per edge.
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      state_r <= IDLE;
      q_r     <= Q_ZERO;
      e_r     <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      cnt_r   <= CNT_ZERO;
      dir_r   <= 1'b0;
    end else begin
      done_r <= 1'b0;
      if (SCLR) begin
        // Also aborts a running shift without a DONE pulse.
        state_r <= IDLE;
        q_r     <= Q_ZERO;
        e_r     <= 1'b0;
        busy_r  <= 1'b0;
        cnt_r   <= CNT_ZERO;
      end else begin
        case (state_r)
          IDLE: begin
            if (LD) begin
              q_r <= Data;
            end else if (ADD) begin
              {e_r, q_r} <= sum_s;
            end else if (INC) begin
              q_r <= q_r + Q_ONE;
            end else if (CMA) begin
              q_r <= ~q_r;
            end else if (CIR) begin
              {q_r, e_r} <= {e_r, q_r};
            end else if (CIL) begin
              {e_r, q_r} <= {q_r, e_r};
            end else if (SH_START) begin
              if (SH_AMT != CNT_ZERO) begin
                state_r <= SHIFT;
                busy_r  <= 1'b1;
                cnt_r   <= SH_AMT;
                dir_r   <= SH_DIR;
              end else begin
                // Zero-length shift completes immediately.
                done_r <= 1'b1;
              end
            end else begin
              q_r <= q_r;
            end
          end
          SHIFT: begin
            if (dir_r) begin
              {e_r, q_r} <= {q_r, 1'b0};
            end else begin
              {q_r, e_r} <= {1'b0, q_r};
            end
            cnt_r <= cnt_r - CNT_ONE;
            if (cnt_r == CNT_ONE) begin
              state_r <= IDLE;
              busy_r  <= 1'b0;
              done_r  <= 1'b1;
            end else begin
              state_r <= SHIFT;
            end
          end
          default: begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            cnt_r   <= CNT_ZERO;
          end
        endcase
      end
    end
  end

  assign Q    = q_r;
  assign E    = e_r;
  assign BUSY = busy_r;
  assign DONE = done_r;
  assign Z    = (q_r == Q_ZERO);
  assign N    = q_r[WIDTH-1];

endmodule

// File: tb/tb_ac_reg_unit.sv
// Self-checking bench for ac_reg_unit: directed scenarios followed by random
// command mixes and shifts, checked against an arithmetic reference model.
module tb_ac_reg_unit;
  localparam int W  = 16;
  localparam int AW = 4;
`ifdef AC_OVF_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  // strobe mask order: {SCLR, LD, ADD, INC, CMA, CIR, CIL}
  localparam logic [6:0] M_SCLR = 7'b1000000;
  localparam logic [6:0] M_LD   = 7'b0100000;
  localparam logic [6:0] M_ADD  = 7'b0010000;
  localparam logic [6:0] M_INC  = 7'b0001000;
  localparam logic [6:0] M_CMA  = 7'b0000100;
  localparam logic [6:0] M_CIR  = 7'b0000010;
  localparam logic [6:0] M_CIL  = 7'b0000001;

  logic          CLK = 1'b0;
  logic          CLR, SCLR, LD, ADD, INC, CMA, CIR, CIL, SH_START, SH_DIR;
  logic [W-1:0]  Data;
  logic [AW-1:0] SH_AMT;
  logic [W-1:0]  Q;
  logic          E, Z, N, BUSY, DONE, OVF;

  int checks = 0;
  int errors = 0;
  int m_q = 0;
  int m_e = 0;
  int m_ovf = 0;

  ac_reg_unit #(.WIDTH(W), .AMT_W(AW)) dut (
    .CLK(CLK), .CLR(CLR), .SCLR(SCLR), .Data(Data),
    .LD(LD), .ADD(ADD), .INC(INC), .CMA(CMA), .CIR(CIR), .CIL(CIL),
    .SH_START(SH_START), .SH_DIR(SH_DIR), .SH_AMT(SH_AMT),
    .Q(Q), .E(E), .Z(Z), .N(N), .BUSY(BUSY), .DONE(DONE), .OVF(OVF)
  );

  always #5 CLK = ~CLK;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input int busy_exp, input int done_exp);
    check({tag, ".Q"}, {16'h0000, Q}, m_q);
    check({tag, ".E"}, {31'd0, E}, m_e);
    check({tag, ".Z"}, {31'd0, Z}, (m_q == 0) ? 32'd1 : 32'd0);
    check({tag, ".N"}, {31'd0, N}, (m_q >= 32768) ? 32'd1 : 32'd0);
    check({tag, ".BUSY"}, {31'd0, BUSY}, busy_exp);
    check({tag, ".DONE"}, {31'd0, DONE}, done_exp);
    check({tag, ".OVF"}, {31'd0, OVF}, OVF_EN ? m_ovf : 0);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Reference: highest-priority strobe wins, computed with plain arithmetic.
  task automatic model_op(input logic [6:0] m, input int d);
    int s, sa, sb, ss, ne;
    if (m[6]) begin
      m_q = 0; m_e = 0; m_ovf = 0;
    end else if (m[5]) begin
      m_q = d;
    end else if (m[4]) begin
      s  = m_q + d;
      sa = (m_q >= 32768) ? m_q - 65536 : m_q;
      sb = (d >= 32768) ? d - 65536 : d;
      ss = sa + sb;
      m_ovf = (ss > 32767 || ss < -32768) ? 1 : 0;
      m_e = s / 65536;
      m_q = s % 65536;
    end else if (m[3]) begin
      m_q = (m_q + 1) % 65536;
    end else if (m[2]) begin
      m_q = 65535 - m_q;
    end else if (m[1]) begin
      ne  = m_q % 2;
      m_q = m_q / 2 + m_e * 32768;
      m_e = ne;
    end else if (m[0]) begin
      ne  = m_q / 32768;
      m_q = (m_q * 2) % 65536 + m_e;
      m_e = ne;
    end
  endtask

  task automatic op(input string tag, input logic [6:0] m, input logic [15:0] d);
    {SCLR, LD, ADD, INC, CMA, CIR, CIL} = m;
    Data = d;
    tick();
    {SCLR, LD, ADD, INC, CMA, CIR, CIL} = 7'b0000000;
    model_op(m, int'(d));
    check_all(tag, 0, 0);
  endtask

  task automatic shift(input string tag, input logic dir, input int amt, input logic inc_during);
    SH_START = 1'b1;
    SH_DIR   = dir;
    SH_AMT   = amt[AW-1:0];
    tick();
    SH_START = 1'b0;
    if (amt == 0) begin
      check_all({tag, ".zero"}, 0, 1);
      tick();
      check_all({tag, ".zero_after"}, 0, 0);
    end else begin
      check({tag, ".busy0"}, {31'd0, BUSY}, 1);
      check({tag, ".done0"}, {31'd0, DONE}, 0);
      INC = inc_during;
      for (int i = 1; i < amt; i++) begin
        SH_DIR = ~SH_DIR;
        SH_AMT = 4'($urandom_range(0, 15));
        SH_START = 1'($urandom_range(0, 1));
        tick();
        check({tag, ".busy"}, {31'd0, BUSY}, 1);
        check({tag, ".done_mid"}, {31'd0, DONE}, 0);
      end
      tick();
      INC = 1'b0;
      SH_START = 1'b0;
      if (dir) begin
        m_e = (m_q >> (16 - amt)) & 1;
        m_q = (m_q << amt) % 65536;
      end else begin
        m_e = (m_q >> (amt - 1)) & 1;
        m_q = m_q >> amt;
      end
      check_all({tag, ".end"}, 0, 1);
      tick();
      check_all({tag, ".after"}, 0, 0);
    end
  endtask

  initial begin
    logic [6:0] m;
    CLR = 1'b1;
    {SCLR, LD, ADD, INC, CMA, CIR, CIL, SH_START, SH_DIR} = 9'd0;
    Data = 16'h0000;
    SH_AMT = 4'd0;
    #2;
    check_all("reset", 0, 0);
    @(negedge CLK);
    CLR = 1'b0;
    tick();
    check_all("idle", 0, 0);

    // carry out of ADD, then INC keeps E
    op("ld_ffff", M_LD, 16'hFFFF);
    op("add_wrap", M_ADD, 16'h0001);
    op("inc_keep_e", M_INC, 16'h0000);
    op("inc_wrap_ld", M_LD, 16'hFFFF);
    op("inc_wrap", M_INC, 16'h0000);

    // priority
    op("ld_beats_add", M_LD | M_ADD, 16'h1234);
    op("sclr_beats_ld", M_SCLR | M_LD, 16'h5555);
    op("add_beats_inc", M_ADD | M_INC | M_CMA, 16'h0F0F);
    op("cma", M_CMA | M_CIR, 16'h0000);

    // right shift by 3 with INC ignored while busy
    op("clr_e", M_SCLR, 16'h0000);
    op("ld_8001", M_LD, 16'h8001);
    shift("shr3", 1'b0, 3, 1'b1);

    // rotates through E
    op("setup_e1a", M_LD, 16'hFFFF);
    op("setup_e1b", M_ADD, 16'h0001);
    op("ld_00f0", M_LD, 16'h00F0);
    op("cil", M_CIL, 16'h0000);
    op("cir", M_CIR, 16'h0000);
    shift("sh0", 1'b1, 0, 1'b0);
    shift("shl5", 1'b1, 5, 1'b0);
    shift("shr15", 1'b0, 15, 1'b1);

    // overflow flag
    op("ld_7fff", M_LD, 16'h7FFF);
    op("add_ovf", M_ADD, 16'h0001);
    op("ovf_hold", M_CMA, 16'h0000);
    op("ovf_hold2", M_CMA, 16'h0000);
    op("add_noovf", M_ADD, 16'h0001);
    op("ld_8000", M_LD, 16'h8000);
    op("add_negovf", M_ADD, 16'h8000);
    op("sclr_ovf", M_SCLR, 16'h0000);

    // SCLR aborts a shift without DONE
    op("ld_abort", M_LD, 16'hA5A5);
    SH_START = 1'b1; SH_DIR = 1'b0; SH_AMT = 4'd5;
    tick();
    SH_START = 1'b0;
    check("abort.busy", {31'd0, BUSY}, 1);
    tick();
    SCLR = 1'b1;
    tick();
    SCLR = 1'b0;
    model_op(M_SCLR, 0);
    check_all("abort", 0, 0);
    tick();
    check_all("abort_after", 0, 0);

    // asynchronous CLR mid-shift
    op("ld_clr", M_LD, 16'h3C3C);
    SH_START = 1'b1; SH_DIR = 1'b1; SH_AMT = 4'd6;
    tick();
    SH_START = 1'b0;
    tick();
    #2;
    CLR = 1'b1;
    #1;
    m_q = 0; m_e = 0; m_ovf = 0;
    check_all("clr_async", 0, 0);
    @(negedge CLK);
    CLR = 1'b0;
    tick();
    check_all("clr_after", 0, 0);

    // random command mixes and shifts
    for (int i = 0; i < 150; i++) begin
      m[6] = ($urandom_range(0, 15) == 0);
      for (int b = 0; b < 6; b++) m[b] = ($urandom_range(0, 3) == 0);
      op("rnd", m, 16'($urandom_range(0, 65535)));
      if (i % 12 == 5)
        shift("rshift", 1'($urandom_range(0, 1)), $urandom_range(0, 15), 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
